// File: rtl/t_cnt_pkg.sv
// Shared definitions for the T flip-flop counter family.
// Holds the direction encoding and a helper that builds an all-ones value.
package t_cnt_pkg;

    localparam logic CNT_DN = 1'b0;
    localparam logic CNT_UP = 1'b1;

    // All-ones value of width w. Valid for w from 1 to 64.
    function automatic logic [63:0] all_ones(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop with a per-cell reset value.
// The reset is synchronous and active-low.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic rst_val,
    output logic q,
    output logic q_bar
);

    logic state_d;
    logic state_q;

    // Toggle when t is high, hold otherwise.
    always_comb begin
        state_d = t ? ~state_q : state_q;
    end

    // State register; rst_val is loaded on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= rst_val;
        end else begin
            state_q <= state_d;
        end
    end

    assign q     = state_q;
    assign q_bar = ~state_q;

endmodule

// File: rtl/t_ff_updown_counter.sv
// WIDTH-bit synchronous up/down counter built from a chain of T flip-flop cells.
// It has parallel load, a count enable, a combinational terminal count and a
// sticky overflow flag.
// Define COUNTER_SAT_EN to make the counter saturate at its end points instead
// of wrapping.
module t_ff_updown_counter
    import t_cnt_pkg::*;
#(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] q_bar_vec;
    logic [WIDTH-1:0] t_vec;
    logic [WIDTH-1:0] up_chain;
    logic [WIDTH-1:0] dn_chain;
    logic             count_up;
    logic             wrap;
    logic             ovf_d;
    logic             ovf_q;

    // Build the toggle inputs. A load toggles exactly the bits that differ from din.
    // Counting toggles bit i when all lower bits are 1 (counting up) or all
    // lower bits are 0 (counting down).
    always_comb begin
        up_chain    = '0;
        dn_chain    = '0;
        up_chain[0] = 1'b1;
        dn_chain[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_chain[i] = up_chain[i-1] & q_vec[i-1];
            dn_chain[i] = dn_chain[i-1] & q_bar_vec[i-1];
        end

        count_up = (up_dn == CNT_UP);
        tc       = en & (count_up ? (q_vec == MAX) : (q_vec == '0));
        wrap     = tc & ~load;

        t_vec = '0;
        if (load) begin
            t_vec = q_vec ^ din;
        end else if (en) begin
            t_vec = count_up ? up_chain : dn_chain;
`ifdef COUNTER_SAT_EN
            if (wrap) begin
                t_vec = '0;
            end
`endif
        end
    end

    // One T cell per bit. Each cell resets to the matching INIT bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .t       (t_vec[i]),
            .rst_val (INIT[i]),
            .q       (q_vec[i]),
            .q_bar   (q_bar_vec[i])
        );
    end

    // Sticky overflow. A wrap or saturate edge sets it, and a set beats a clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (wrap) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_vec;
    assign ovf = ovf_q;

endmodule

// File: doc/t_ff_updown_counter.md
Name: t_ff_updown_counter

Overview:
- Synchronous WIDTH-bit up/down binary counter built from a chain of T flip-flop cells; consumes the T-FF stage by generating each cell's T input from the lower-order bits.
- Provides parallel load, count enable, a terminal-count flag and a sticky overflow flag.
- Sits downstream of the T-FF primitive as the first multi-bit sequential building block for timers and dividers.

Parameters:
- WIDTH, 4, counter width in bits (≥2).
- INIT, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- load  input  1  parallel load strobe.
- din  input  WIDTH  parallel load value.
- clr_ovf  input  1  clears sticky overflow flag.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational.
- ovf  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Reset (rst=0 at a rising edge): q <= INIT, ovf <= 0. Reset overrides all other inputs.
- Priority per edge: rst > load > en. With rst=1 and load=1: q <= din, no count, ovf unaffected by the load.
- Count (rst=1, load=0, en=1): bit i toggles.
  - When up_dn=1: T_i = en & AND(q[i-1:0]), with T_0 = en.
  - When up_dn=0: T_i = en & AND(~q[i-1:0]).
  - Result is q+1 or q-1 modulo 2^WIDTH, one-cycle latency.
- Hold: en=0 and load=0 -> q unchanged.
- tc = en & (up_dn ? q==all-ones : q==0). It is the ripple-out for cascading and is independent of load.
- Wrap: an edge where tc=1 and load=0 and rst=1 wraps q (MAX->0 up, 0->MAX down) and sets ovf <= 1.
- ovf: sticky until clr_ovf=1 at an edge. If a wrap and clr_ovf coincide, the set wins (ovf=1).
- Direction change takes effect on the same edge up_dn is sampled; no glitch state.
- Load of din==MAX or din==0 does not set ovf.

Optional Feature:
- Macro COUNTER_SAT_EN.
- When defined: counter saturates instead of wrapping. At MAX counting up, or at 0 counting down, all T inputs are forced to 0 and q holds. ovf is still set on the saturated edge. tc definition is unchanged.
- When undefined: modulo wrap as above.

Decomposition:
- Shared package t_cnt_pkg holds:
  - direction constants CNT_DN=1'b0 and CNT_UP=1'b1;
  - a helper function for all-ones of a given width.
- Sub-module t_ff_cell: a single T flip-flop with ports clk, rst (sync active-low), t, rst_val, q, q_bar.
  - q <= rst_val on reset.
  - q toggles when t=1, holds otherwise.
  - q_bar = ~q.
- Top level instantiates WIDTH cells in a generate loop. A load is applied by driving t = q ^ din[i].

Test Plan:
- Reset: hold rst=0 for 2 edges with en=1, load=1, din=4'hA -> q=0 (INIT), ovf=0; release and see q stay 0 with en=0.
- Up count and wrap: load 4'hD, then en=1, up_dn=1 for 4 edges -> q=E,F,0,1. tc=1 only while q=F. ovf rises on the F->0 edge and stays 1.
- Down count and underflow: load 4'h1, en=1, up_dn=0 for 3 edges -> q=0,F,E. tc=1 while q=0. ovf set. Pulse clr_ovf -> ovf=0 next edge.
- Priority and simultaneity:
  - load=1, en=1, din=4'h7 -> q=7 (no count).
  - At q=F up, assert clr_ovf with en=1 -> q=0, ovf=1 (set wins).
- Mid-operation reset: counting up at q=9, drop rst for one edge with load=1 -> q=0, ovf=0; next edge resumes counting from 0 to 1.
- With COUNTER_SAT_EN: from q=E count up 3 edges -> q=F,F,F and ovf=1. From q=1 count down 3 edges -> q=0,0,0.
